// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: runs the multi-cycle data-memory access for the
// instruction held in the EX/MEM latch and registers the MEM/WB fields.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ALUOut_EM,
  input  logic        compareResult_EM,
  input  logic [15:0] PC2_EM,
  input  logic [1:0]  regWriteDataSel_EM,
  input  logic        memWriteEnable_EM,
  input  logic        memReadEnable_EM,
  input  logic        halt_EM,
  input  logic [15:0] R2Data_EM,
  input  logic        nop_EM,
  input  logic [2:0]  regWriteNum_EM,
  input  logic        regWriteEnable_EM,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        en_EM,
  output logic [15:0] regWriteData_MW,
  output logic [2:0]  regWriteNum_MW,
  output logic        regWriteEnable_MW,
  output logic        halt_MW,
  output logic        valid_MW,
  output logic        mem_err,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic        acc;
  logic        is_halt;
  logic        timeout;
  logic        commit;
  logic [15:0] wb_data;

  assign state_dbg = state;
  assign mem_addr  = ALUOut_EM;
  assign mem_wdata = R2Data_EM;
  assign mem_wr    = memWriteEnable_EM;
  assign is_halt   = halt_EM & ~nop_EM;
  assign acc       = (memReadEnable_EM | memWriteEnable_EM) & ~nop_EM & (state != HALTED);
  assign timeout   = (state == WAIT) & ~mem_done & (cnt == 6'(TIMEOUT - 1));

  always_comb begin
    wb_data = ALUOut_EM;
    case (regWriteDataSel_EM)
      2'b00: wb_data = ALUOut_EM;
      2'b01: wb_data = mem_rdata;
      2'b10: wb_data = PC2_EM;
      2'b11: wb_data = {15'b0, compareResult_EM};
      default: wb_data = ALUOut_EM;
    endcase
  end

  // Handshake: mem_req is a single-cycle pulse while the EX/MEM fields are
  // stable; the memory answers with mem_done (rdata valid) in that cycle or a
  // later one. en_EM is low for every cycle the instruction has not retired.
  always_comb begin
    mem_req = 1'b0;
    en_EM   = 1'b1;
    commit  = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          mem_req = acc;
          commit  = ~acc | mem_done;
          en_EM   = commit;
        end
        WAIT: begin
          commit = mem_done;
          en_EM  = mem_done | timeout;
        end
        HALTED: en_EM = 1'b0;
        default: en_EM = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      mem_err           <= 1'b0;
      regWriteData_MW   <= '0;
      regWriteNum_MW    <= '0;
      regWriteEnable_MW <= 1'b0;
      halt_MW           <= 1'b0;
      valid_MW          <= 1'b0;
    end else begin
      case (state)
        IDLE, WAIT: begin
          if (commit) begin
            regWriteData_MW   <= wb_data;
            regWriteNum_MW    <= regWriteNum_EM;
            regWriteEnable_MW <= regWriteEnable_EM & ~nop_EM;
            halt_MW           <= is_halt;
            valid_MW          <= ~nop_EM;
            state             <= is_halt ? HALTED : IDLE;
          end else begin
            regWriteData_MW   <= '0;
            regWriteNum_MW    <= '0;
            regWriteEnable_MW <= 1'b0;
            halt_MW           <= 1'b0;
            valid_MW          <= 1'b0;
            if (state == IDLE) begin
              cnt   <= '0;
              state <= WAIT;
            end else if (timeout) begin
              // Give up on the access; the instruction is dropped.
              mem_err <= 1'b1;
              state   <= IDLE;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized bench for mem_stage_ctrl: each instruction is issued with a chosen
// memory latency and the expected MEM/WB sequence is queued from that latency.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ALUOut_EM, PC2_EM, R2Data_EM, mem_rdata;
  logic        compareResult_EM, memWriteEnable_EM, memReadEnable_EM;
  logic        halt_EM, nop_EM, regWriteEnable_EM, mem_done;
  logic [1:0]  regWriteDataSel_EM;
  logic [2:0]  regWriteNum_EM;
  logic        mem_req, mem_wr, en_EM, regWriteEnable_MW, halt_MW, valid_MW, mem_err;
  logic [15:0] mem_addr, mem_wdata, regWriteData_MW;
  logic [2:0]  regWriteNum_MW;
  logic [1:0]  state_dbg;

  mem_stage_ctrl #(.TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .ALUOut_EM(ALUOut_EM), .compareResult_EM(compareResult_EM), .PC2_EM(PC2_EM),
    .regWriteDataSel_EM(regWriteDataSel_EM), .memWriteEnable_EM(memWriteEnable_EM),
    .memReadEnable_EM(memReadEnable_EM), .halt_EM(halt_EM), .R2Data_EM(R2Data_EM),
    .nop_EM(nop_EM), .regWriteNum_EM(regWriteNum_EM), .regWriteEnable_EM(regWriteEnable_EM),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .en_EM(en_EM),
    .regWriteData_MW(regWriteData_MW), .regWriteNum_MW(regWriteNum_MW),
    .regWriteEnable_MW(regWriteEnable_MW), .halt_MW(halt_MW), .valid_MW(valid_MW),
    .mem_err(mem_err), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  // {check_data, data[15:0], num[2:0], wen, halt, valid}
  logic [22:0] exp_q[$];
  logic [21:0] last_mw;
  logic        halted_m;
  logic        err_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] wb_of(input logic [15:0] rdata);
    case (regWriteDataSel_EM)
      2'b00: return ALUOut_EM;
      2'b01: return rdata;
      2'b10: return PC2_EM;
      default: return {15'b0, compareResult_EM};
    endcase
  endfunction

  task automatic set_instr(input logic [15:0] alu, input logic [1:0] sel, input logic rd,
                           input logic wr, input logic hlt, input logic nop,
                           input logic [2:0] num, input logic wen);
    ALUOut_EM = alu; regWriteDataSel_EM = sel; memReadEnable_EM = rd;
    memWriteEnable_EM = wr; halt_EM = hlt; nop_EM = nop;
    regWriteNum_EM = num; regWriteEnable_EM = wen;
    PC2_EM = 16'($urandom); R2Data_EM = 16'($urandom);
    compareResult_EM = 1'($urandom);
  endtask

  task automatic do_reset(input logic done);
    rst = 1'b1;
    mem_done = done;
    @(negedge clk);
    check("rst_en", en_EM, 1);
    check("rst_req", mem_req, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_done = 1'b0;
    check("rst_mw", {regWriteData_MW, regWriteNum_MW, regWriteEnable_MW, halt_MW, valid_MW}, 0);
    check("rst_err", mem_err, 0);
    exp_q.delete();
    last_mw = '0;
    halted_m = 1'b0;
    err_m = 1'b0;
  endtask

  // driver: one clock cycle with the expected outcome of that cycle
  task automatic cycle(input logic done, input logic [15:0] rdata, input logic exp_en,
                       input logic exp_req, input logic load, input logic bubble);
    logic [22:0] e;
    mem_done = done;
    mem_rdata = rdata;
    if (load)
      exp_q.push_back({1'b1, wb_of(rdata), regWriteNum_EM, regWriteEnable_EM & ~nop_EM,
                       halt_EM & ~nop_EM, ~nop_EM});
    else if (bubble)
      exp_q.push_back(23'd0);
    else
      exp_q.push_back({1'b1, last_mw});
    @(negedge clk);
    check("en_EM", en_EM, exp_en);
    check("mem_req", mem_req, exp_req);
    if (exp_req) begin
      check("mem_wr", mem_wr, memWriteEnable_EM);
      check("mem_addr", mem_addr, ALUOut_EM);
      check("mem_wdata", mem_wdata, R2Data_EM);
    end
    @(posedge clk); #1;
    mem_done = 1'b0;
    e = exp_q.pop_front();
    check("valid_MW", valid_MW, e[0]);
    check("halt_MW", halt_MW, e[1]);
    check("wen_MW", regWriteEnable_MW, e[2]);
    if (e[22]) begin
      check("num_MW", regWriteNum_MW, e[5:3]);
      check("data_MW", regWriteData_MW, e[21:6]);
    end
    check("mem_err", mem_err, err_m);
    if (load || !bubble) last_mw = e[21:0];
  endtask

  // Issue the current EX/MEM instruction; for an access, mem_done arrives
  // lat cycles after the request cycle (lat > 64 means never).
  task automatic run_instr(input int lat, input logic [15:0] rdata);
    logic acc;
    acc = (memReadEnable_EM | memWriteEnable_EM) & ~nop_EM;
    if (halted_m) begin
      cycle(1'($urandom), rdata, 1'b0, 1'b0, 1'b0, 1'b0);
    end else if (!acc) begin
      cycle(1'($urandom), rdata, 1'b1, 1'b0, 1'b1, 1'b0);
      if (halt_EM && !nop_EM) halted_m = 1'b1;
    end else begin
      for (int i = 0; i <= 64; i++) begin
        if (i == lat) begin
          cycle(1'b1, rdata, 1'b1, i == 0, 1'b1, 1'b0);
          if (halt_EM && !nop_EM) halted_m = 1'b1;
          break;
        end else if (i == 64) begin
          err_m = 1'b1;
          cycle(1'b0, rdata, 1'b1, 1'b0, 1'b0, 1'b1);
        end else begin
          cycle(1'b0, rdata, 1'b0, i == 0, 1'b0, 1'b1);
        end
      end
    end
  endtask

  initial begin
    int lat;
    rst = 1'b1; mem_done = 1'b0; mem_rdata = '0;
    set_instr(16'h0, 2'b00, 0, 0, 0, 1, 3'd0, 0);
    @(posedge clk); #1;
    do_reset(1'b0);

    // ALU op
    set_instr(16'h1234, 2'b00, 0, 0, 0, 0, 3'd3, 1);
    run_instr(0, 16'h0);
    // load hit
    set_instr(16'h0040, 2'b01, 1, 0, 0, 0, 3'd5, 1);
    run_instr(0, 16'hBEEF);
    check("hit_data", regWriteData_MW, 16'hBEEF);
    // store miss, done after 3 cycles
    set_instr(16'h0080, 2'b00, 0, 1, 0, 0, 3'd1, 0);
    R2Data_EM = 16'h00AA;
    run_instr(3, 16'h0);
    // timeout
    set_instr(16'h0100, 2'b01, 1, 0, 0, 0, 3'd2, 1);
    run_instr(1000, 16'h0);
    check("to_state_idle", state_dbg, 2'd0);
    check("to_err", mem_err, 1);
    // reset arriving mid-WAIT together with mem_done
    set_instr(16'h0200, 2'b01, 1, 0, 0, 0, 3'd4, 1);
    cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    set_instr(16'h0, 2'b00, 0, 0, 0, 0, 3'd0, 0);
    do_reset(1'b1);
    @(negedge clk);
    check("post_rst_en", en_EM, 1);
    @(posedge clk); #1;
    exp_q.delete();
    last_mw = {regWriteData_MW, regWriteNum_MW, regWriteEnable_MW, halt_MW, valid_MW};
    // halt
    set_instr(16'h0, 2'b10, 0, 0, 1, 0, 3'd7, 0);
    run_instr(0, 16'h0);
    check("halt_MW_set", halt_MW, 1);
    for (int k = 0; k < 4; k++) begin
      set_instr(16'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 0, 0, 3'($urandom), 1);
      run_instr(0, 16'($urandom));
    end
    do_reset(1'b0);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      set_instr(16'($urandom), 2'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0, 3'($urandom), 1'($urandom));
      lat = ($urandom_range(0, 29) == 0) ? 100 : $urandom_range(0, 5);
      run_instr(lat, 16'($urandom));
      if (halted_m && $urandom_range(0, 2) == 0) do_reset(1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
